// File: rtl/dev_bus_master.sv
// dev_bus_master: CPU-side initiator for the peripheral bus.
// It decodes CPU load/store addresses into 16-byte device windows and drives
// the shared ADD_O/DAT_O/WE_O lines. Load data comes back registered, with a
// one-cycle cpu_ack pulse. Device IRQ lines are collected into a maskable
// pending register that drives a single int_req output.
// Ports:
//   CLK_I, RST_I                 clock, async active-low reset
//   cpu_req/we/addr/wdata        CPU request, held until cpu_ack
//   cpu_rdata/ack/err            CPU response (valid while cpu_ack=1)
//   ADD_O, DAT_O, WE_O           device register select, write data, one-hot strobe
//   DAT_I                        device read data, device k at [32k+31:32k]
//   IRQ_I                        level interrupt lines from devices
//   int_req                      |(pending & mask)
// The window at index NDEV holds the bridge's own registers:
//   +0 MASK (RW), +4 PENDING (R, write-1-to-clear), +8/+C read as zero.
module dev_bus_master #(
   parameter logic [31:0] BASE_ADDR = 32'h0000_7F00,
   parameter int          NDEV      = 2
) (
   input  logic                 CLK_I,
   input  logic                 RST_I,
   input  logic                 cpu_req,
   input  logic                 cpu_we,
   input  logic [31:0]          cpu_addr,
   input  logic [31:0]          cpu_wdata,
   output logic [31:0]          cpu_rdata,
   output logic                 cpu_ack,
   output logic                 cpu_err,
   output logic [1:0]           ADD_O,
   output logic [31:0]          DAT_O,
   output logic [NDEV-1:0]      WE_O,
   input  logic [32*NDEV-1:0]   DAT_I,
   input  logic [NDEV-1:0]      IRQ_I,
   output logic                 int_req
);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   state_t          state;
   logic [3:0]      idx_r;
   logic            we_r;
   logic [NDEV-1:0] mask, pending, irq_prev;

   logic [31:0]     win_idx;
   logic            legal;
   logic            is_bridge, bw;
   logic [NDEV-1:0] mask_next, clr, pending_next, we_hot;
   logic [31:0]     rd_mux;

   // Address decode on the live CPU request. A wrap-around from an address
   // below BASE_ADDR is rejected by the explicit lower-bound compare.
   always_comb begin
      win_idx = (cpu_addr - BASE_ADDR) >> 4;
      legal   = (cpu_addr >= BASE_ADDR) && (win_idx <= 32'(NDEV)) &&
                (cpu_addr[1:0] == 2'b00);
      we_hot  = '0;
      for (int k = 0; k < NDEV; k++)
         we_hot[k] = cpu_we && (win_idx[3:0] == 4'(k));
   end

   // Bridge register updates happen only in ACCESS. Error responses skip
   // that state, so they can never write MASK or clear PENDING.
   always_comb begin
      is_bridge    = (idx_r == 4'(NDEV));
      bw           = (state == ACCESS) && we_r && is_bridge;
      mask_next    = (bw && ADD_O == 2'd0) ? DAT_O[NDEV-1:0] : mask;
      clr          = (bw && ADD_O == 2'd1) ? DAT_O[NDEV-1:0] : '0;
      // A new edge in the same cycle as a W1C of the same bit keeps the bit set.
      pending_next = (pending & ~clr) | (IRQ_I & ~irq_prev);
   end

   always_comb begin
      rd_mux = '0;
      if (is_bridge) begin
         case (ADD_O)
            2'd0:    rd_mux[NDEV-1:0] = mask;
            2'd1:    rd_mux[NDEV-1:0] = pending;
            default: rd_mux = '0;
         endcase
      end else begin
         for (int k = 0; k < NDEV; k++)
            if (idx_r == 4'(k)) rd_mux = DAT_I[32*k +: 32];
      end
   end

   always_ff @(posedge CLK_I or negedge RST_I) begin
      if (!RST_I) begin
         state     <= IDLE;
         idx_r     <= '0;
         we_r      <= 1'b0;
         cpu_ack   <= 1'b0;
         cpu_err   <= 1'b0;
         cpu_rdata <= '0;
         ADD_O     <= '0;
         DAT_O     <= '0;
         WE_O      <= '0;
         mask      <= '0;
         pending   <= '0;
         irq_prev  <= '0;
         int_req   <= 1'b0;
      end else begin
         irq_prev <= IRQ_I;
         mask     <= mask_next;
         pending  <= pending_next;
         int_req  <= |(pending_next & mask_next);
         case (state)
            IDLE: begin
               cpu_ack   <= 1'b0;
               cpu_err   <= 1'b0;
               cpu_rdata <= '0;
               WE_O      <= '0;
               if (cpu_req) begin
                  if (legal) begin
                     state <= ACCESS;
                     idx_r <= win_idx[3:0];
                     we_r  <= cpu_we;
                     ADD_O <= cpu_addr[3:2];
                     DAT_O <= cpu_wdata;
                     WE_O  <= we_hot;   // zero for the bridge window
                  end else begin
                     state   <= RESP;
                     cpu_ack <= 1'b1;
                     cpu_err <= 1'b1;
                  end
               end
            end
            ACCESS: begin
               WE_O      <= '0;
               cpu_ack   <= 1'b1;
               cpu_err   <= 1'b0;
               cpu_rdata <= we_r ? 32'h0 : rd_mux;
               state     <= RESP;
            end
            RESP: begin
               cpu_ack   <= 1'b0;
               cpu_err   <= 1'b0;
               cpu_rdata <= '0;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dev_bus_master.sv
// Bench for dev_bus_master. The tasks drive CPU accesses and push the expected
// response onto a scoreboard. A negedge monitor pops that entry when cpu_ack
// arrives and compares it.
module tb_dev_bus_master;
   localparam int NDEV = 2;

   logic               CLK_I = 1'b0;
   logic               RST_I = 1'b0;
   logic               cpu_req = 1'b0, cpu_we = 1'b0;
   logic [31:0]        cpu_addr = '0, cpu_wdata = '0;
   logic [31:0]        cpu_rdata;
   logic               cpu_ack, cpu_err, int_req;
   logic [1:0]         ADD_O;
   logic [31:0]        DAT_O;
   logic [NDEV-1:0]    WE_O;
   logic [32*NDEV-1:0] DAT_I = {32'hDEAD_BEEF, 32'h1234_5678};
   logic [NDEV-1:0]    IRQ_I = '0;

   int errors = 0;
   int checks = 0;

   typedef struct packed {logic err; logic [31:0] rd;} exp_t;
   exp_t exp_q[$];

   dev_bus_master #(.BASE_ADDR(32'h0000_7F00), .NDEV(NDEV)) dut (
      .CLK_I(CLK_I), .RST_I(RST_I), .cpu_req(cpu_req), .cpu_we(cpu_we),
      .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
      .cpu_ack(cpu_ack), .cpu_err(cpu_err), .ADD_O(ADD_O), .DAT_O(DAT_O),
      .WE_O(WE_O), .DAT_I(DAT_I), .IRQ_I(IRQ_I), .int_req(int_req));

   always #5 CLK_I = ~CLK_I;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   // scoreboard monitor
   always @(negedge CLK_I) begin : mon
      exp_t e;
      if (RST_I && cpu_ack) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_ack: err=%b rdata=%h, no response expected", cpu_err, cpu_rdata);
         end else begin
            e = exp_q.pop_front();
            if ({cpu_err, cpu_rdata} !== e) begin
               errors++;
               $display("FAIL response: got err=%b rdata=%h, expected err=%b rdata=%h",
                        cpu_err, cpu_rdata, e.err, e.rd);
            end
         end
      end
   end

   // One access. Returns the latency in cycles to ack, and the bus lines seen
   // in the first cycle after the request was sampled. irq_acc is ORed into
   // IRQ_I during that cycle.
   task automatic bus(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                      input logic exp_err, input logic [31:0] exp_rd,
                      input logic [NDEV-1:0] irq_acc,
                      output int lat, output logic [NDEV-1:0] we1,
                      output logic [1:0] add1, output logic [31:0] dat1,
                      output int we_cnt);
      logic got;
      exp_q.push_back({exp_err, exp_rd});
      @(negedge CLK_I);
      cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
      lat = 0; we_cnt = 0; got = 1'b0;
      we1 = '0; add1 = '0; dat1 = '0;
      while (!got && lat < 8) begin
         @(negedge CLK_I);
         lat++;
         if (WE_O != '0) we_cnt++;
         if (lat == 1) begin
            we1 = WE_O; add1 = ADD_O; dat1 = DAT_O;
            IRQ_I = IRQ_I | irq_acc;
         end
         if (cpu_ack) got = 1'b1;
      end
      cpu_req = 1'b0;
      if (!got) begin
         checks++; errors++;
         $display("FAIL ack_timeout: addr=%h no ack within 8 cycles", addr);
         void'(exp_q.pop_back());
      end
   endtask

   // Shorthand for register accesses where only the scoreboard check matters.
   task automatic simple(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [31:0] exp_rd);
      int lat, wc; logic [NDEV-1:0] w1; logic [1:0] a1; logic [31:0] d1;
      bus(we, addr, wd, 1'b0, exp_rd, '0, lat, w1, a1, d1, wc);
   endtask

   task automatic test_reset();
      repeat (2) @(negedge CLK_I);
      checks++;
      if ({cpu_ack, cpu_err, cpu_rdata, ADD_O, DAT_O, WE_O, int_req} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: ack=%b err=%b rdata=%h add=%h dat=%h we=%b int=%b, expected all 0",
                  cpu_ack, cpu_err, cpu_rdata, ADD_O, DAT_O, WE_O, int_req);
      end
      RST_I = 1'b1;
      @(negedge CLK_I);
   endtask

   task automatic test_store();
      int lat, wc; logic [NDEV-1:0] w1; logic [1:0] a1; logic [31:0] d1;
      bus(1'b1, 32'h7F00, 32'h9, 1'b0, 32'h0, '0, lat, w1, a1, d1, wc);
      checks++;
      if (lat !== 2 || w1 !== 2'b01 || a1 !== 2'd0 || d1 !== 32'h9 || wc !== 1) begin
         errors++;
         $display("FAIL store_dev0: lat=%0d we=%b add=%0d dat=%h strobes=%0d, expected 2 01 0 9 1",
                  lat, w1, a1, d1, wc);
      end
      @(negedge CLK_I);
      checks++;
      if (cpu_ack !== 1'b0 || WE_O !== '0) begin
         errors++;
         $display("FAIL ack_pulse: ack=%b we=%b one cycle after ack, expected 0 00", cpu_ack, WE_O);
      end
      bus(1'b1, 32'h7F18, 32'hA5, 1'b0, 32'h0, '0, lat, w1, a1, d1, wc);
      checks++;
      if (w1 !== 2'b10 || a1 !== 2'd2 || d1 !== 32'hA5 || wc !== 1) begin
         errors++;
         $display("FAIL store_dev1: we=%b add=%0d dat=%h strobes=%0d, expected 10 2 a5 1", w1, a1, d1, wc);
      end
   endtask

   task automatic test_load();
      int lat, wc; logic [NDEV-1:0] w1; logic [1:0] a1; logic [31:0] d1;
      bus(1'b0, 32'h7F14, 32'h0, 1'b0, 32'hDEAD_BEEF, '0, lat, w1, a1, d1, wc);
      checks++;
      if (lat !== 2 || a1 !== 2'd1 || wc !== 0) begin
         errors++;
         $display("FAIL load_dev1: lat=%0d add=%0d strobes=%0d, expected 2 1 0", lat, a1, wc);
      end
      bus(1'b0, 32'h7F0C, 32'h0, 1'b0, 32'h1234_5678, '0, lat, w1, a1, d1, wc);
      checks++;
      if (lat !== 2 || a1 !== 2'd3 || wc !== 0) begin
         errors++;
         $display("FAIL load_dev0: lat=%0d add=%0d strobes=%0d, expected 2 3 0", lat, a1, wc);
      end
   endtask

   task automatic test_errors();
      logic [31:0] addrs [5] = '{32'h7F02, 32'h7F30, 32'h7EFC, 32'h7F21, 32'h7F01};
      logic        wes   [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      int lat, wc; logic [NDEV-1:0] w1; logic [1:0] a1; logic [31:0] d1;
      for (int i = 0; i < 5; i++) begin
         bus(wes[i], addrs[i], 32'hFFFF_FFFF, 1'b1, 32'h0, '0, lat, w1, a1, d1, wc);
         checks++;
         if (lat !== 1 || wc !== 0) begin
            errors++;
            $display("FAIL error_access: addr=%h lat=%0d strobes=%0d, expected 1 0", addrs[i], lat, wc);
         end
      end
      // a misaligned store into the MASK register must not change it
      simple(1'b0, 32'h7F20, 32'h0, 32'h0);
   endtask

   task automatic test_irq_w1c();
      int lat, wc; logic [NDEV-1:0] w1; logic [1:0] a1; logic [31:0] d1;
      simple(1'b1, 32'h7F20, 32'h1, 32'h0);
      @(negedge CLK_I); IRQ_I = 2'b01;
      @(negedge CLK_I);
      checks++;
      if (int_req !== 1'b1) begin
         errors++; $display("FAIL irq_raise: int_req=%b, expected 1", int_req);
      end
      simple(1'b0, 32'h7F24, 32'h0, 32'h1);
      simple(1'b1, 32'h7F24, 32'h1, 32'h0);
      checks++;
      if (int_req !== 1'b0) begin
         errors++; $display("FAIL irq_w1c: int_req=%b after clear, expected 0", int_req);
      end
      simple(1'b0, 32'h7F24, 32'h0, 32'h0);   // level still high: no re-set
      IRQ_I = 2'b00; @(negedge CLK_I);
      IRQ_I = 2'b01; @(negedge CLK_I);
      checks++;
      if (int_req !== 1'b1) begin
         errors++; $display("FAIL irq_rearm: int_req=%b, expected 1", int_req);
      end
      simple(1'b0, 32'h7F24, 32'h0, 32'h1);
      // a new edge in the same cycle as the W1C of that bit leaves it set
      IRQ_I = 2'b00; @(negedge CLK_I);
      bus(1'b1, 32'h7F24, 32'h1, 1'b0, 32'h0, 2'b01, lat, w1, a1, d1, wc);
      simple(1'b0, 32'h7F24, 32'h0, 32'h1);
      simple(1'b1, 32'h7F24, 32'h3, 32'h0);
      simple(1'b0, 32'h7F24, 32'h0, 32'h0);
      IRQ_I = 2'b00;
   endtask

   task automatic test_irq_mask();
      simple(1'b1, 32'h7F20, 32'h0, 32'h0);
      @(negedge CLK_I); IRQ_I = 2'b10;
      repeat (2) @(negedge CLK_I);
      checks++;
      if (int_req !== 1'b0) begin
         errors++; $display("FAIL irq_masked: int_req=%b, expected 0", int_req);
      end
      simple(1'b0, 32'h7F24, 32'h0, 32'h2);
      simple(1'b1, 32'h7F20, 32'h2, 32'h0);
      checks++;
      if (int_req !== 1'b1) begin
         errors++; $display("FAIL irq_unmask: int_req=%b after MASK=10, expected 1", int_req);
      end
      simple(1'b0, 32'h7F20, 32'h0, 32'h2);
      simple(1'b1, 32'h7F20, 32'hFFFF_FFFF, 32'h0);
      simple(1'b0, 32'h7F20, 32'h0, 32'h3);         // upper mask bits read 0
      simple(1'b0, 32'h7F28, 32'h0, 32'h0);
      simple(1'b1, 32'h7F2C, 32'h5, 32'h0);
      simple(1'b0, 32'h7F20, 32'h0, 32'h3);         // write to +C ignored
      IRQ_I = 2'b00;
      simple(1'b1, 32'h7F24, 32'h3, 32'h0);
      simple(1'b1, 32'h7F20, 32'h1, 32'h0);
   endtask

   task automatic test_back_to_back();
      int n1, n2;
      exp_q.push_back({1'b0, 32'h0});
      exp_q.push_back({1'b0, 32'hDEAD_BEEF});
      @(negedge CLK_I);
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h7F04; cpu_wdata = 32'h5;
      n1 = 0;
      do begin @(negedge CLK_I); n1++; end while (!cpu_ack && n1 < 8);
      cpu_we = 1'b0; cpu_addr = 32'h7F10;            // request stays high
      n2 = 0;
      do begin @(negedge CLK_I); n2++; end while (!cpu_ack && n2 < 8);
      cpu_req = 1'b0;
      checks++;
      if (n1 !== 2 || n2 !== 3) begin
         errors++;
         $display("FAIL back_to_back: first ack after %0d, second after %0d more, expected 2 and 3", n1, n2);
      end
   endtask

   task automatic test_reset_mid_access();
      int bad;
      @(negedge CLK_I);
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h7F00; cpu_wdata = 32'h7;
      @(negedge CLK_I);
      RST_I = 1'b0;
      #1;
      checks++;
      if ({cpu_ack, cpu_err, cpu_rdata, ADD_O, DAT_O, WE_O, int_req} !== '0) begin
         errors++;
         $display("FAIL reset_mid: ack=%b we=%b add=%h dat=%h int=%b, expected all 0",
                  cpu_ack, WE_O, ADD_O, DAT_O, int_req);
      end
      cpu_req = 1'b0;
      @(negedge CLK_I); RST_I = 1'b1;
      bad = 0;
      repeat (5) begin
         @(negedge CLK_I);
         if (cpu_ack || WE_O != '0) bad++;
      end
      checks++;
      if (bad !== 0) begin
         errors++; $display("FAIL reset_release: %0d cycles with ack/strobe, expected 0", bad);
      end
      simple(1'b0, 32'h7F20, 32'h0, 32'h0);          // mask back to 0
   endtask

   initial begin
      test_reset();
      test_store();
      test_load();
      test_errors();
      test_irq_w1c();
      test_irq_mask();
      test_back_to_back();
      test_reset_mid_access();
      repeat (2) @(negedge CLK_I);
      checks++;
      if (exp_q.size() !== 0) begin
         errors++; $display("FAIL leftover_expect: %0d responses never arrived, expected 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
